// File: rtl/hazard_unit.sv
// hazard_unit: load-use / CSR interlocks, memory-wait freeze and trap/branch flush control.
// Build option: define HAZARD_PERF_COUNT_EN to enable the stall_count performance counter.

typedef enum logic [1:0] {
  NoType = 2'd0,
  Type1  = 2'd1,
  Type2  = 2'd2,
  Type3  = 2'd3
} forwarding_type_t;

module hazard_unit #(
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  forwarding_type_t           forwarding_type_id,
  input  logic [4:0]                 rs1_id,
  input  logic [4:0]                 rs2_id,
  input  logic [4:0]                 rd_ex,
  input  logic [4:0]                 rd_mem,
  input  logic                       reg_we_ex,
  input  logic                       mem_rd_en_ex,
  input  logic                       mem_rd_en_mem,
  input  logic                       zicsr_ex,
  input  logic                       mem_req_mem,
  input  logic                       mem_ack,
  input  logic                       branch_taken_id,
  input  logic                       trap_mem,
  output logic                       stall_if,
  output logic                       stall_id,
  output logic                       stall_ex,
  output logic                       stall_mem,
  output logic                       bubble_ex,
  output logic                       bubble_wb,
  output logic                       flush_id,
  output logic                       flush_ex,
  output logic                       flush_mem,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BUBBLE   = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  state_t     r_ret, w_ret_nxt;
  state_t     w_eff;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic [1:0] w_depth;

  logic w_reads, w_is_t2, w_mem_wait;
  logic w_rs1_ex, w_rs2_ex, w_rs1_mem, w_rs2_mem;
  logic w_src_ex, w_src_mem;

  // x0 never creates a dependency; NoType instructions read no registers
  assign w_reads    = (forwarding_type_id != NoType);
  assign w_is_t2    = (forwarding_type_id == Type2);
  assign w_rs1_ex   = w_reads && (rs1_id == rd_ex)  && (rd_ex  != 5'd0);
  assign w_rs2_ex   = w_reads && (rs2_id == rd_ex)  && (rd_ex  != 5'd0);
  assign w_rs1_mem  = w_reads && (rs1_id == rd_mem) && (rd_mem != 5'd0);
  assign w_rs2_mem  = w_reads && (rs2_id == rd_mem) && (rd_mem != 5'd0);
  assign w_src_ex   = w_rs1_ex  || w_rs2_ex;
  assign w_src_mem  = w_rs1_mem || w_rs2_mem;
  assign w_mem_wait = mem_req_mem && !mem_ack;

  // A stalled memory access resumes whatever it interrupted
  assign w_eff = (r_state == MEM_WAIT) ? r_ret : r_state;

  always_comb begin
    w_depth = 2'd0;
    if (w_is_t2 && mem_rd_en_ex && w_src_ex)
      w_depth = 2'd2;
    else if (mem_rd_en_ex && w_src_ex)
      w_depth = 2'd1;
    else if (w_is_t2 && reg_we_ex && !mem_rd_en_ex && (w_rs2_ex || (w_rs1_ex && !zicsr_ex)))
      w_depth = 2'd1;
    else if (w_is_t2 && mem_rd_en_mem && w_src_mem)
      w_depth = 2'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_cnt_nxt   = r_cnt;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    bubble_ex   = 1'b0;
    bubble_wb   = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    flush_mem   = 1'b0;
    if (reset || trap_mem) begin
      flush_id    = 1'b1;
      flush_ex    = 1'b1;
      flush_mem   = 1'b1;
      w_state_nxt = RUN;
      w_ret_nxt   = RUN;
      w_cnt_nxt   = 2'd0;
    end else if (w_mem_wait) begin
      stall_if    = 1'b1;
      stall_id    = 1'b1;
      stall_ex    = 1'b1;
      stall_mem   = 1'b1;
      bubble_wb   = 1'b1;
      w_state_nxt = MEM_WAIT;
      w_ret_nxt   = w_eff;
    end else begin
      case (w_eff)
        BUBBLE: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          if (r_cnt <= 2'd1) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = RUN;
          end else begin
            w_cnt_nxt   = r_cnt - 2'd1;
            w_state_nxt = BUBBLE;
          end
        end
        default: begin
          w_state_nxt = RUN;
          if (w_depth != 2'd0) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
            if (w_depth == 2'd2) begin
              w_state_nxt = BUBBLE;
              w_cnt_nxt   = w_depth - 2'd1;
            end
          end else begin
            flush_id = branch_taken_id;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
      r_ret   <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_COUNT_EN
  logic [STALL_CNT_WIDTH-1:0] r_stall_count;

  always_ff @(posedge clock) begin
    if (reset)
      r_stall_count <= '0;
    else if (stall_id)
      r_stall_count <= r_stall_count + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scoreboard bench for hazard_unit (stall/bubble/flush and stall_count).
module tb_hazard_unit;
  localparam int W = 32;

  // flag order: stall_if stall_id stall_ex stall_mem bubble_ex bubble_wb flush_id flush_ex flush_mem
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] RSTF = 9'b000000111;
  localparam logic [8:0] HAZ  = 9'b110010000;
  localparam logic [8:0] MW   = 9'b111101000;
  localparam logic [8:0] TRAP = 9'b000000111;
  localparam logic [8:0] BRF  = 9'b000000100;

  logic             clock = 1'b0;
  logic             reset;
  forwarding_type_t fwd;
  logic [4:0]       rs1, rs2, rdex, rdmem;
  logic             we_ex, ld_ex, ld_mem, csr_ex, mreq, mack, br, trap;
  logic             s_if, s_id, s_ex, s_mem, b_ex, b_wb, f_id, f_ex, f_mem;
  logic [W-1:0]     scnt;

  typedef struct packed {
    logic [8:0]   flags;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_fail   = 0;
  logic [W-1:0] m_cnt    = '0;

  hazard_unit #(.STALL_CNT_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .forwarding_type_id(fwd),
    .rs1_id(rs1), .rs2_id(rs2), .rd_ex(rdex), .rd_mem(rdmem),
    .reg_we_ex(we_ex), .mem_rd_en_ex(ld_ex), .mem_rd_en_mem(ld_mem), .zicsr_ex(csr_ex),
    .mem_req_mem(mreq), .mem_ack(mack), .branch_taken_id(br), .trap_mem(trap),
    .stall_if(s_if), .stall_id(s_id), .stall_ex(s_ex), .stall_mem(s_mem),
    .bubble_ex(b_ex), .bubble_wb(b_wb), .flush_id(f_id), .flush_ex(f_ex), .flush_mem(f_mem),
    .stall_count(scnt)
  );

  always #5 clock = ~clock;

  task automatic idle();
    reset = 1'b0; fwd = NoType; rs1 = '0; rs2 = '0; rdex = '0; rdmem = '0;
    we_ex = 1'b0; ld_ex = 1'b0; ld_mem = 1'b0; csr_ex = 1'b0;
    mreq = 1'b0; mack = 1'b0; br = 1'b0; trap = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clock);
    idle();
  endtask

  // Queue the expectation for the cycle just driven, then compare once outputs settle.
  task automatic step(input string tag, input logic [8:0] exp_flags);
    exp_t       e;
    exp_t       got;
    logic [8:0] obs;
    e.flags = exp_flags;
`ifdef HAZARD_PERF_COUNT_EN
    e.cnt = m_cnt;
`else
    e.cnt = '0;
`endif
    sb.push_back(e);
    #1;
    obs = {s_if, s_id, s_ex, s_mem, b_ex, b_wb, f_id, f_ex, f_mem};
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      assert (obs === got.flags) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s flags obs=%b exp=%b", tag, obs, got.flags);
      end
      n_checks++;
      assert (scnt === got.cnt) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s stall_count obs=%0d exp=%0d", tag, scnt, got.cnt);
      end
    end
    // counter reference advances on the coming rising edge
    if (reset) m_cnt = '0;
    else if (exp_flags[7]) m_cnt = m_cnt + 1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    nxt(); reset = 1'b1; trap = 1'b1; step("rst0", RSTF);
    nxt(); reset = 1'b1; fwd = Type2; ld_ex = 1'b1; rdex = 5'd7; rs1 = 5'd7; mreq = 1'b1;
    step("rst1", RSTF);
    nxt(); step("idle", NONE);

    // single-cycle load-use
    nxt(); fwd = Type1; ld_ex = 1'b1; we_ex = 1'b1; rdex = 5'd5; rs1 = 5'd5; step("ld_t1", HAZ);
    nxt(); step("ld_t1_run", NONE);

    // two-cycle Type2 load-use
    nxt(); fwd = Type2; ld_ex = 1'b1; we_ex = 1'b1; rdex = 5'd7; rs2 = 5'd7; step("ld_t2_c0", HAZ);
    nxt(); step("ld_t2_c1", HAZ);
    nxt(); step("ld_t2_run", NONE);

    // Zicsr in EX: rs1 is forwardable, rs2 is not
    nxt(); fwd = Type2; csr_ex = 1'b1; we_ex = 1'b1; rdex = 5'd3; rs1 = 5'd3; step("csr_rs1", NONE);
    nxt(); fwd = Type2; csr_ex = 1'b1; we_ex = 1'b1; rdex = 5'd3; rs2 = 5'd3; step("csr_rs2", HAZ);
    nxt(); step("csr_run", NONE);

    // x0, NoType, MEM-stage load
    nxt(); fwd = Type1; ld_ex = 1'b1; rdex = 5'd0; rs1 = 5'd0; step("x0", NONE);
    nxt(); fwd = NoType; ld_ex = 1'b1; rdex = 5'd5; rs1 = 5'd5; step("notype", NONE);
    nxt(); fwd = Type2; ld_mem = 1'b1; rdmem = 5'd9; rs1 = 5'd9; step("ldmem_t2", HAZ);
    nxt(); fwd = Type1; ld_mem = 1'b1; rdmem = 5'd9; rs1 = 5'd9; step("ldmem_t1", NONE);
    nxt(); fwd = Type3; ld_ex = 1'b1; rdex = 5'd12; rs2 = 5'd12; step("ld_t3", HAZ);

    // memory wait freezes the pending bubble
    nxt(); fwd = Type2; ld_ex = 1'b1; rdex = 5'd7; rs1 = 5'd7; step("mw_haz", HAZ);
    for (int i = 0; i < 3; i++) begin
      nxt(); mreq = 1'b1; step("mw_freeze", MW);
    end
    nxt(); step("mw_resume", HAZ);
    nxt(); step("mw_run", NONE);
    nxt(); mreq = 1'b1; mack = 1'b1; step("zero_wait", NONE);
    nxt(); mreq = 1'b1; step("mw_run_freeze", MW);
    nxt(); step("mw_run_back", NONE);

    // trap during bubble and during memory wait
    nxt(); fwd = Type2; ld_ex = 1'b1; rdex = 5'd7; rs2 = 5'd7; step("tr_haz", HAZ);
    nxt(); trap = 1'b1; br = 1'b1; step("trap_bub", TRAP);
    nxt(); step("trap_run", NONE);
    nxt(); mreq = 1'b1; trap = 1'b1; step("trap_mw", TRAP);

    // branch flush only when ID is not stalled
    nxt(); fwd = Type1; ld_ex = 1'b1; rdex = 5'd4; rs1 = 5'd4; br = 1'b1; step("br_stall", HAZ);
    nxt(); br = 1'b1; step("br_flush", BRF);
    nxt(); mreq = 1'b1; br = 1'b1; step("br_mw", MW);
    nxt(); step("br_back", NONE);

    // reset abandons bubble and memory wait
    nxt(); fwd = Type2; ld_ex = 1'b1; rdex = 5'd8; rs1 = 5'd8; step("rb_haz", HAZ);
    nxt(); reset = 1'b1; step("rb_rst", RSTF);
    nxt(); step("rb_run", NONE);
    nxt(); fwd = Type2; ld_ex = 1'b1; rdex = 5'd8; rs1 = 5'd8; step("rm_haz", HAZ);
    nxt(); mreq = 1'b1; step("rm_mw", MW);
    nxt(); reset = 1'b1; mreq = 1'b1; step("rm_rst", RSTF);
    nxt(); step("rm_run", NONE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter STALL_CNT_WIDTH, default 32, width of the stall-cycle counter.
REQ-002 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port forwarding_type_id  in  forwarding_type_t  operand class of the ID instruction (NoType/Type1/Type2/Type3).
REQ-005 SHALL have ports rs1_id, rs2_id, rd_ex, rd_mem  in  5 each  register indices.
REQ-006 SHALL have ports reg_we_ex, mem_rd_en_ex, mem_rd_en_mem, zicsr_ex  in  1 each  EX writes rd / EX is a load / MEM is a load / EX is Zicsr.
REQ-007 SHALL have ports mem_req_mem, mem_ack  in  1 each  MEM data access pending / memory completes this cycle.
REQ-008 SHALL have ports branch_taken_id, trap_mem  in  1 each  ID redirect / MEM trap.
REQ-009 SHALL have outputs stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, flush_id, flush_ex, flush_mem  out  1 each.
REQ-010 SHALL have output stall_count  out  STALL_CNT_WIDTH  stalled-cycle count.

Function
REQ-011 match(rs,rd) SHALL be (rs==rd) && (rd!=0); ID reads rs1/rs2 iff forwarding_type_id != NoType.
REQ-012 Hazard depth D SHALL be: 2 if Type2 and mem_rd_en_ex and match(rs1_id|rs2_id, rd_ex); else 1 if mem_rd_en_ex and a read source matches rd_ex (any type); else 1 if Type2, reg_we_ex, !mem_rd_en_ex, and rs2_id matches rd_ex, or rs1_id matches rd_ex with !zicsr_ex; else 1 if Type2, mem_rd_en_mem, and a source matches rd_mem; else 0.
REQ-013 FSM states SHALL be RUN, BUBBLE, MEM_WAIT; internal down-counter cnt, 2 bits.
REQ-014 RUN with D>0 and no mem-wait/trap: assert stall_if, stall_id, bubble_ex this cycle; next state BUBBLE with cnt=D-1 if D==2, else stay RUN.
REQ-015 BUBBLE: assert stall_if, stall_id, bubble_ex; cnt decrements each cycle; return to RUN when cnt reaches 0 after the decrement; new hazards are not re-evaluated in BUBBLE.
REQ-016 Mem-wait = mem_req_mem && !mem_ack: SHALL assert stall_if, stall_id, stall_ex, stall_mem, bubble_wb combinationally, deassert bubble_ex, freeze cnt; state MEM_WAIT remembers the return state (RUN or BUBBLE).
REQ-017 mem_ack in the same cycle as mem_req_mem SHALL cause no stall (zero-wait access).
REQ-018 branch_taken_id SHALL assert flush_id only when stall_id is low in that cycle; otherwise it is ignored.
REQ-019 trap_mem SHALL assert flush_id, flush_ex, flush_mem, force every stall/bubble output low, force next state RUN, and clear cnt; trap overrides mem-wait and bubbles.
REQ-020 Priority SHALL be reset > trap_mem > mem-wait > bubble > branch flush.
REQ-021 All outputs other than stall_count SHALL be combinational functions of the state, cnt, and inputs; stall_count SHALL be registered.

Reset
REQ-022 On reset the state SHALL be RUN, cnt SHALL be 0, and stall_count SHALL be 0.
REQ-023 During reset, every stall/bubble/flush output SHALL be 0, except flush_id, flush_ex, and flush_mem, which SHALL be 1.
REQ-024 Reset asserted mid-BUBBLE or mid-MEM_WAIT SHALL abandon the operation; the first post-reset cycle evaluates as RUN.

Configuration
REQ-025 Macro HAZARD_PERF_COUNT_EN defined: stall_count SHALL increment by 1 each cycle stall_id is high, wrap modulo 2^STALL_CNT_WIDTH, and hold otherwise.
REQ-026 Macro HAZARD_PERF_COUNT_EN undefined: stall_count port SHALL remain present and be tied to 0, with no counter flops.

Verification
REQ-027 Scenario: EX load with rd_ex=5 and rs1_id=5, Type1 -> exactly 1 cycle stall_id=bubble_ex=1, then RUN.
REQ-028 Scenario: Type2, EX load with rd_ex=7 and rs2_id=7 -> 2 consecutive stall cycles; stall_count +2 with HAZARD_PERF_COUNT_EN.
REQ-029 Scenario: Type2, zicsr_ex=1, rd_ex=3, rs1_id=3, not a load -> no stall; same stimulus with rs2_id=3 -> 1 stall.
REQ-030 Scenario: mem_req_mem=1 with mem_ack low for 3 cycles during BUBBLE (cnt=1) -> 3 freeze cycles with bubble_ex=0, then the remaining bubble cycle.
REQ-031 Scenario: trap_mem=1 in BUBBLE -> flush_id/ex/mem=1, all stalls 0, RUN on the next cycle; branch_taken_id during a stall -> flush_id=0.
REQ-032 Scenario: rd_ex=0 with rs1_id=0 on an EX load -> no stall.
